// File: rtl/clk_div_reconfig_ctrl_if.sv
// Configuration handshake and divided-clock outputs of the reconfigurable divider.
// The master side requests ratios; the slave side is the divider itself.
interface clk_div_reconfig_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             i_cfg_valid;
  logic [CNT_W-1:0] i_cfg_div;
  logic             o_cfg_ready;
  logic             o_cfg_err;
  logic             o_clk;
  logic             o_tick;
  logic             o_locked;
  logic [CNT_W-1:0] o_div_cur;

  modport master (
    output i_cfg_valid, i_cfg_div,
    input  o_cfg_ready, o_cfg_err, o_clk, o_tick, o_locked, o_div_cur
  );

  modport slave (
    input  i_cfg_valid, i_cfg_div,
    output o_cfg_ready, o_cfg_err, o_clk, o_tick, o_locked, o_div_cur
  );
endinterface

// File: rtl/clk_div_reconfig_ctrl.sv
// Runtime-reconfigurable clock divider: new ratios take effect only at a period
// boundary, followed by a quiet settle window, so no runt pulses reach downstream.
module clk_div_reconfig_ctrl #(
  parameter int CNT_W         = 16,
  parameter int DEFAULT_DIV   = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  clk_div_reconfig_ctrl_if.slave  bus
);

  localparam int               SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DIV_RST     = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN     = CNT_W'(2);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] pending;
  logic [SW-1:0]    settle_cnt;
  logic             clk_q;
  logic             tick_q;
  logic             err_q;
  logic             locked_q;

  logic             wrap;
  logic             accept;
  logic             clk_next;

  assign wrap     = (cnt == div - CNT_W'(1));
  assign accept   = bus.i_cfg_valid && (state == RUN);
  assign clk_next = (cnt < (div >> 1));

  // Single registered stage: counter, FSM and all outputs update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= RUN;
      cnt        <= '0;
      div        <= DIV_RST;
      pending    <= '0;
      settle_cnt <= '0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        RUN: begin
          cnt    <= wrap ? '0 : cnt + CNT_W'(1);
          clk_q  <= clk_next;
          tick_q <= wrap;
          if (wrap) locked_q <= 1'b1;
          if (accept) begin
            if (bus.i_cfg_div < DIV_MIN) begin
              err_q <= 1'b1;
            end else if (bus.i_cfg_div != div) begin
              pending  <= bus.i_cfg_div;
              state    <= DRAIN;
              locked_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          clk_q    <= clk_next;
          tick_q   <= wrap;
          locked_q <= 1'b0;
          if (wrap) begin
            // Old period has just completed in full; swap ratio at the boundary.
            cnt <= '0;
            div <= pending;
            if (SETTLE_CYCLES == 0) begin
              state <= RUN;
            end else begin
              state      <= SETTLE;
              settle_cnt <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SETTLE: begin
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
          cnt    <= '0;
          if (settle_cnt == SETTLE_LAST) state <= RUN;
          else settle_cnt <= settle_cnt + SW'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

  assign bus.o_cfg_ready = (state == RUN);
  assign bus.o_cfg_err   = err_q;
  assign bus.o_clk       = clk_q;
  assign bus.o_tick      = tick_q;
  assign bus.o_locked    = locked_q;
  assign bus.o_div_cur   = div;

endmodule

// File: tb/tb_clk_div_reconfig_ctrl.sv
// Bench for clk_div_reconfig_ctrl: waveform-queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_clk_div_reconfig_ctrl;
  localparam int CNT_W         = 16;
  localparam int DEFAULT_DIV   = 2;
  localparam int SETTLE_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  clk_div_reconfig_ctrl_if #(.CNT_W(CNT_W)) bus ();

  clk_div_reconfig_ctrl #(
    .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Model: the future output waveform is a queue of samples, one per clock edge.
  // Whole periods (or settle gaps) are appended whenever the queue runs dry.
  typedef struct packed {
    logic hi;
    logic tk;
    logic settle;
  } ent_t;

  ent_t wq[$];
  int   m_div, m_pend;
  bit   m_pend_v, m_clk, m_tick, m_err, m_locked;
  bit   mdl_ok = 1'b0;

  function automatic void push_period(input int d);
    ent_t e;
    for (int i = 0; i < d; i++) begin
      e.hi     = (i < d / 2);
      e.tk     = (i == d - 1);
      e.settle = 1'b0;
      wq.push_back(e);
    end
  endfunction

  function automatic void push_settle();
    ent_t e;
    e.hi = 1'b0; e.tk = 1'b0; e.settle = 1'b1;
    for (int i = 0; i < SETTLE_CYCLES; i++) wq.push_back(e);
  endfunction

  function automatic void m_reset();
    wq.delete();
    m_div    = DEFAULT_DIV;
    m_pend   = 0;
    m_pend_v = 1'b0;
    m_clk    = 1'b0;
    m_tick   = 1'b0;
    m_err    = 1'b0;
    m_locked = 1'b0;
    push_period(DEFAULT_DIV);
  endfunction

  function automatic bit m_ready();
    return !m_pend_v && !wq[0].settle;
  endfunction

  initial begin
    forever begin
      ent_t e;
      bit   was_pend, rdy;
      int   req;
      @(posedge clk);
      if (rst) begin
        m_reset();
        mdl_ok = 1'b1;
      end else if (mdl_ok) begin
        rdy      = m_ready();
        was_pend = m_pend_v;
        e        = wq.pop_front();
        m_clk    = e.hi;
        m_tick   = e.tk;
        m_err    = 1'b0;
        if (rdy && bus.i_cfg_valid) begin
          req = int'(bus.i_cfg_div);
          if (req < 2) m_err = 1'b1;
          else if (req != m_div) begin
            m_pend   = req;
            m_pend_v = 1'b1;
            m_locked = 1'b0;
          end
        end
        if (e.tk && !m_pend_v) m_locked = 1'b1;
        if (e.tk && was_pend) begin
          m_div    = m_pend;
          m_pend_v = 1'b0;
          push_settle();
        end
        if (wq.size() == 0) push_period(m_div);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mdl_ok) begin
        chk("m_clk",    bus.o_clk,       m_clk);
        chk("m_tick",   bus.o_tick,      m_tick);
        chk("m_err",    bus.o_cfg_err,   m_err);
        chk("m_locked", bus.o_locked,    m_locked);
        chk("m_ready",  bus.o_cfg_ready, m_ready());
        chk("m_div",    bus.o_div_cur,   m_div);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    bit saw5;
    int clkp [9] = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
    int tickp[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

    bus.i_cfg_valid = 1'b0;
    bus.i_cfg_div   = '0;
    step(2);
    rst = 1'b0;

    // Idle at the default ratio of 2
    step(1);
    chk("t1_clk_a",  bus.o_clk, 1);
    chk("t1_tick_a", bus.o_tick, 0);
    chk("t1_lock_a", bus.o_locked, 0);
    step(1);
    chk("t1_clk_b",  bus.o_clk, 0);
    chk("t1_tick_b", bus.o_tick, 1);
    chk("t1_lock_b", bus.o_locked, 1);
    chk("t1_div",    bus.o_div_cur, 2);
    step(1);
    chk("t1_clk_c",  bus.o_clk, 1);
    step(3);

    // Illegal ratios 1 and 0
    bus.i_cfg_valid = 1'b1; bus.i_cfg_div = 16'd1;
    step(1);
    chk("t3_err1", bus.o_cfg_err, 1);
    bus.i_cfg_div = 16'd0;
    step(1);
    chk("t3_err0", bus.o_cfg_err, 1);
    bus.i_cfg_valid = 1'b0;
    step(1);
    chk("t3_err_clr", bus.o_cfg_err, 0);
    chk("t3_div",     bus.o_div_cur, 2);
    chk("t3_lock",    bus.o_locked, 1);

    // Same ratio: no-op
    bus.i_cfg_valid = 1'b1; bus.i_cfg_div = 16'd2;
    step(1);
    bus.i_cfg_valid = 1'b0;
    chk("t4_ready", bus.o_cfg_ready, 1);
    chk("t4_lock",  bus.o_locked, 1);
    chk("t4_div",   bus.o_div_cur, 2);
    step(3);

    // Switch 2 -> 5; data line changes after accept
    bus.i_cfg_valid = 1'b1; bus.i_cfg_div = 16'd5;
    step(1);
    bus.i_cfg_valid = 1'b0; bus.i_cfg_div = 16'd7;
    chk("t2_ready_drain", bus.o_cfg_ready, 0);
    chk("t2_lock_drain",  bus.o_locked, 0);
    n = 0;
    while (bus.o_div_cur != 16'd5 && n < 20) begin step(1); n++; end
    chk("t2_switch_div",  bus.o_div_cur, 5);
    chk("t2_switch_tick", bus.o_tick, 1);
    chk("t2_switch_clk",  bus.o_clk, 0);
    chk("t2_switch_rdy",  bus.o_cfg_ready, 0);
    for (int i = 0; i < 9; i++) begin
      step(1);
      chk($sformatf("t2_clk%0d", i),  bus.o_clk,  clkp[i]);
      chk($sformatf("t2_tick%0d", i), bus.o_tick, tickp[i]);
      if (i == 3) chk("t2_ready_run", bus.o_cfg_ready, 1);
      if (i == 7) chk("t2_lock_pre",  bus.o_locked, 0);
      if (i == 8) chk("t2_lock_post", bus.o_locked, 1);
    end

    // Move to 3, then request 5 and hold 8 through the switch
    bus.i_cfg_valid = 1'b1; bus.i_cfg_div = 16'd3;
    step(1);
    bus.i_cfg_valid = 1'b0;
    n = 0;
    while (!bus.o_locked && n < 40) begin step(1); n++; end
    chk("t5_lock3", bus.o_locked, 1);
    chk("t5_div3",  bus.o_div_cur, 3);
    bus.i_cfg_valid = 1'b1; bus.i_cfg_div = 16'd5;
    step(1);
    bus.i_cfg_div = 16'd8;
    chk("t5_ready_drain", bus.o_cfg_ready, 0);
    n = 0; saw5 = 1'b0;
    while (!bus.o_cfg_ready && n < 40) begin
      step(1); n++;
      if (bus.o_div_cur == 16'd5) saw5 = 1'b1;
    end
    chk("t5_ready_run", bus.o_cfg_ready, 1);
    chk("t5_saw5",      saw5, 1);
    step(1);
    bus.i_cfg_valid = 1'b0;
    chk("t5_ready_drain8", bus.o_cfg_ready, 0);
    n = 0;
    while (bus.o_div_cur != 16'd8 && n < 40) begin step(1); n++; end
    chk("t5_div8", bus.o_div_cur, 8);
    n = 0;
    while (!bus.o_locked && n < 40) begin step(1); n++; end
    chk("t5_lock8", bus.o_locked, 1);

    // Reset during DRAIN towards 6
    bus.i_cfg_valid = 1'b1; bus.i_cfg_div = 16'd6;
    step(1);
    bus.i_cfg_valid = 1'b0;
    chk("t6_ready_drain", bus.o_cfg_ready, 0);
    step(2);
    rst = 1'b1;
    step(1);
    chk("t6_clk",   bus.o_clk, 0);
    chk("t6_tick",  bus.o_tick, 0);
    chk("t6_lock",  bus.o_locked, 0);
    chk("t6_ready", bus.o_cfg_ready, 1);
    chk("t6_err",   bus.o_cfg_err, 0);
    chk("t6_div",   bus.o_div_cur, 2);
    rst = 1'b0;
    step(20);
    chk("t6_div_late",  bus.o_div_cur, 2);
    chk("t6_lock_late", bus.o_locked, 1);
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
